// File: rtl/time_keeper_if.sv
// Key/display bundle between the debouncers, time_keeper and the seven-segment driver.
interface time_keeper_if;
  logic        key_set;
  logic        key_sub;
  logic        key_add;
  logic [12:0] time_out;
  logic [5:0]  sec_out;
  logic [1:0]  mode;
  logic        sec_tick;

  modport slave (
    input  key_set, key_sub, key_add,
    output time_out, sec_out, mode, sec_tick
  );

  modport master (
    output key_set, key_sub, key_add,
    input  time_out, sec_out, mode, sec_tick
  );
endinterface

// File: rtl/time_keeper.sv
// HH:MM:SS time-of-day counter with key-driven hour/minute setting.
// Optional hold-to-repeat on add/sub keys: TIME_KEEPER_AUTOREPEAT_EN.
module time_keeper #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned REPEAT_DELAY  = CLK_FREQ / 2,
  parameter int unsigned REPEAT_PERIOD = CLK_FREQ / 5
) (
  input  logic         clk,
  input  logic         rst,
  time_keeper_if.slave tk
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PSC_TC = PW'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  mode_e         state_q, state_d;
  logic [2:0]    keys, hist_q, press_q;   // [2]=set [1]=sub [0]=add
  logic [PW-1:0] psc_q, psc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    hour_q, hour_d;
  logic [6:0]    min_q, min_d;
  logic          tick_q, tick_d;
  logic          run_en, edit_hour, edit_min;
  logic          rpt_add, rpt_sub, step_up, step_dn;

  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    if (h == 6'h23)       return '0;
    if (h[3:0] == 4'd9)   return {h[5:4] + 2'd1, 4'd0};
    return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [5:0] hour_dec(input logic [5:0] h);
    if (h == 6'h00)       return 6'h23;
    if (h[3:0] == 4'd0)   return {h[5:4] - 2'd1, 4'd9};
    return {h[5:4], h[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] min_inc(input logic [6:0] m);
    if (m == 7'h59)       return '0;
    if (m[3:0] == 4'd9)   return {m[6:4] + 3'd1, 4'd0};
    return {m[6:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] min_dec(input logic [6:0] m);
    if (m == 7'h00)       return 7'h59;
    if (m[3:0] == 4'd0)   return {m[6:4] - 3'd1, 4'd9};
    return {m[6:4], m[3:0] - 4'd1};
  endfunction

  assign keys = {tk.key_set, tk.key_sub, tk.key_add};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '1;
      press_q <= '0;
    end else begin
      hist_q  <= keys;
      press_q <= hist_q & ~keys;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press_q[2]) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end
  end

  // A set press on the same cycle masks both counting and editing.
  always_comb begin
    run_en    = (state_q == RUN)      && !press_q[2];
    edit_hour = (state_q == SET_HOUR) && !press_q[2];
    edit_min  = (state_q == SET_MIN)  && !press_q[2];
  end

`ifdef TIME_KEEPER_AUTOREPEAT_EN
  logic [31:0] rpt_q, rpt_d;
  logic        held, rpt_fire;

  // After the first repeat the counter is rewound so later steps come every REPEAT_PERIOD.
  always_comb begin
    held     = (state_q != RUN) && (hist_q[0] ^ hist_q[1]);
    rpt_fire = held && (rpt_q == 32'(REPEAT_DELAY));
    rpt_d    = '0;
    if (held && !press_q[2])
      rpt_d = rpt_fire ? 32'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rpt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rpt_q <= '0;
    else      rpt_q <= rpt_d;
  end

  assign rpt_add = rpt_fire & ~hist_q[0];
  assign rpt_sub = rpt_fire & ~hist_q[1];
`else
  localparam int unsigned UNUSED_RPT = REPEAT_DELAY + REPEAT_PERIOD;
  assign rpt_add = 1'b0;
  assign rpt_sub = 1'b0;
`endif

  assign step_up = (press_q[0] | rpt_add) & ~(press_q[1] | rpt_sub);
  assign step_dn = (press_q[1] | rpt_sub) & ~(press_q[0] | rpt_add);

  always_comb begin
    psc_d  = '0;
    sec_d  = '0;
    hour_d = hour_q;
    min_d  = min_q;
    tick_d = 1'b0;
    if (run_en) begin
      sec_d = sec_q;
      if (psc_q == PSC_TC) begin
        tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          min_d = min_inc(min_q);
          if (min_q == 7'h59) hour_d = hour_inc(hour_q);
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end else if (edit_hour) begin
      if (step_up)      hour_d = hour_inc(hour_q);
      else if (step_dn) hour_d = hour_dec(hour_q);
    end else if (edit_min) begin
      if (step_up)      min_d = min_inc(min_q);
      else if (step_dn) min_d = min_dec(min_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q  <= '0;
      sec_q  <= '0;
      hour_q <= '0;
      min_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      sec_q  <= sec_d;
      hour_q <= hour_d;
      min_q  <= min_d;
      tick_q <= tick_d;
    end
  end

  assign tk.time_out = {hour_q, min_q};
  assign tk.sec_out  = sec_q;
  assign tk.mode     = state_q;
  assign tk.sec_tick = tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed vector table, multi-cycle corner
// sequences and random key traffic checked against a seconds-of-day model.
module tb_time_keeper;

  localparam int CF = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  time_keeper_if tk ();

  time_keeper #(
    .CLK_FREQ     (CF),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tk (tk)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: mode, edited fields, and for RUN the seconds-of-day at the edge counting started.
  int m_mode, m_hh, m_mm, m_base, m_start;

  typedef struct {
    logic        s, b, a;
    logic [1:0]  m;
    logic [12:0] t;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  function automatic int cur_time(input int e);
    return (m_base + (e - m_start) / CF) % 86400;
  endfunction

  function automatic int to_bcd(input int hh, input int mm);
    return ((hh / 10) << 11) | ((hh % 10) << 7) | ((mm / 10) << 4) | (mm % 10);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_hh    = 0;
    m_mm    = 0;
    m_base  = 0;
    m_start = cyc;
  endtask

  task automatic model_press(input int n, input logic s, input logic b, input logic a);
    int f;
    if (s) begin
      case (m_mode)
        0: begin
          f      = cur_time(n);
          m_hh   = f / 3600;
          m_mm   = (f / 60) % 60;
          m_mode = 1;
        end
        1: m_mode = 2;
        default: begin
          m_mode  = 0;
          m_base  = m_hh * 3600 + m_mm * 60;
          m_start = n + 1;
        end
      endcase
    end else if (a != b) begin
      if (m_mode == 1) m_hh = (m_hh + (a ? 1 : 23)) % 24;
      if (m_mode == 2) m_mm = (m_mm + (a ? 1 : 59)) % 60;
    end
  endtask

  task automatic check_model(input string tag);
    int t, hh, mm, ss, tick;
    if (m_mode == 0) begin
      t    = cur_time(cyc);
      hh   = t / 3600;
      mm   = (t / 60) % 60;
      ss   = t % 60;
      tick = (cyc > m_start && (cyc - m_start) % CF == 0) ? 1 : 0;
    end else begin
      hh = m_hh; mm = m_mm; ss = 0; tick = 0;
    end
    chk({tag, ".time"}, int'(tk.time_out), to_bcd(hh, mm));
    chk({tag, ".sec"},  int'(tk.sec_out),  ss);
    chk({tag, ".mode"}, int'(tk.mode),     m_mode);
    chk({tag, ".tick"}, int'(tk.sec_tick), tick);
  endtask

  // Starts and ends on a falling edge; keys low for two sampling edges then released.
  task automatic press(input logic s, input logic b, input logic a);
    int n;
    tk.key_set = ~s;
    tk.key_sub = ~b;
    tk.key_add = ~a;
    step();
    n = cyc;
    step();
    tk.key_set = 1'b1;
    tk.key_sub = 1'b1;
    tk.key_add = 1'b1;
    model_press(n, s, b, a);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int r;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 13'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 13'h1180};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 13'h0000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd1, 13'h1180};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 13'h1180};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd2, 13'h1180};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2'd2, 13'h11D9};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd2, 13'h1180};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2'd2, 13'h11D9};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 2'd0, 13'h11D9};

    tk.key_set = 1'b1;
    tk.key_sub = 1'b1;
    tk.key_add = 1'b1;

    // Reset values while held, then run from release.
    #2 rst = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst.time", int'(tk.time_out), 0);
    chk("rst.sec",  int'(tk.sec_out),  0);
    chk("rst.mode", int'(tk.mode),     0);
    chk("rst.tick", int'(tk.sec_tick), 0);
    rst = 1'b1;
    model_reset();
    for (int k = 1; k <= 25; k++) begin
      step();
      chk($sformatf("run.tick%0d", k), int'(tk.sec_tick), (k == 10 || k == 20) ? 1 : 0);
    end
    chk("run.sec", int'(tk.sec_out), 2);
    check_model("run");

    // Vector table: hour/minute wraps and simultaneous keys, ending at 23:59 in RUN.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].s, tbl[i].b, tbl[i].a);
      chk($sformatf("vec%0d.mode", i), int'(tk.mode),     int'(tbl[i].m));
      chk($sformatf("vec%0d.time", i), int'(tk.time_out), int'(tbl[i].t));
    end

    // Rollover 23:59:59 -> 00:00:00 at the 60th tick.
    while (cyc < m_start + 599) step();
    chk("roll.pre.time", int'(tk.time_out), 13'h11D9);
    chk("roll.pre.sec",  int'(tk.sec_out),  59);
    step();
    chk("roll.time", int'(tk.time_out), 0);
    chk("roll.sec",  int'(tk.sec_out),  0);
    chk("roll.tick", int'(tk.sec_tick), 1);
    check_model("roll");

    // Async reset in SET_MIN at 12:34 discards the setting.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) press(1'b0, 1'b0, 1'b1);
    chk("mid.pre.time", int'(tk.time_out), 13'h0934);
    chk("mid.pre.mode", int'(tk.mode),     2);
    #2 rst = 1'b0;
    #1;
    chk("mid.time", int'(tk.time_out), 0);
    chk("mid.mode", int'(tk.mode),     0);
    chk("mid.sec",  int'(tk.sec_out),  0);
    @(negedge clk);
    step();
    rst = 1'b1;
    model_reset();

`ifdef TIME_KEEPER_AUTOREPEAT_EN
    // Hold add for 40 cycles in SET_MIN: press + repeats at 20,25,30,35,40.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tk.key_add = 1'b0;
    step();
    repeat (40) step();
    tk.key_add = 1'b1;
    step();
    step();
    chk("rpt.time", int'(tk.time_out), 13'h0006);
`endif

    // Random key traffic against the model.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: press(1'b1, 1'b0, 1'b0);
        2, 3: press(1'b0, 1'b0, 1'b1);
        4, 5: press(1'b0, 1'b1, 1'b0);
        6:    press(1'b0, 1'b1, 1'b1);
        7:    press(1'b1, 1'b0, 1'b1);
        8:    press(1'b1, 1'b1, 1'b0);
        default: repeat ($urandom_range(1, 25)) step();
      endcase
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
